// File: rtl/z16_encoder_if.sv
// Handshake and status bundle for the Z16 field-to-word encoder.
// The master side presents field sets and takes words; the slave side is the encoder.
interface z16_encoder_if #(
  parameter int CNT_W = 16
);
  logic             i_valid;
  logic             o_ready;
  logic [3:0]       i_opcode;
  logic [3:0]       i_rd;
  logic [3:0]       i_rs1;
  logic [3:0]       i_rs2;
  logic [15:0]      i_imm;
  logic             o_valid;
  logic             i_ready;
  logic [15:0]      o_instr;
  logic             o_err;
  logic             o_err_sticky;
  logic             i_err_clr;
  logic [CNT_W-1:0] o_instr_cnt;
  logic [CNT_W-1:0] o_err_cnt;

  modport master (
    output i_valid, i_opcode, i_rd, i_rs1, i_rs2, i_imm, i_ready, i_err_clr,
    input  o_ready, o_valid, o_instr, o_err, o_err_sticky, o_instr_cnt, o_err_cnt
  );

  modport slave (
    input  i_valid, i_opcode, i_rd, i_rs1, i_rs2, i_imm, i_ready, i_err_clr,
    output o_ready, o_valid, o_instr, o_err, o_err_sticky, o_instr_cnt, o_err_cnt
  );
endinterface

// File: rtl/z16_encoder.sv
// Z16 encoder: packs opcode/register/immediate fields into a 16-bit word,
// flags illegal field sets, and buffers results in a 2-entry output FIFO.
//
// state | meaning
// EMPTY | no word buffered, o_valid=0
// ONE   | head holds one word, can still accept
// FULL  | head and tail hold words, o_ready=0
module z16_encoder #(
  parameter int CNT_W = 16
) (
  input logic           i_clk,
  input logic           i_rst_n,
  z16_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state;
  state_t state_nxt;

  logic        push;
  logic        pop;
  logic        err_push;
  logic [15:0] enc_instr;
  logic        enc_err;

  logic [15:0] head_instr;
  logic        head_err;
  logic [15:0] tail_instr;
  logic        tail_err;

  logic        load_head_new;
  logic        load_head_tail;
  logic        load_tail;

  logic [CNT_W-1:0] instr_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             err_sticky;

  assign bus.o_ready = (state != FULL);
  assign bus.o_valid = (state != EMPTY);
  assign push        = bus.i_valid && bus.o_ready;
  assign pop         = bus.o_valid && bus.i_ready;
  assign err_push    = push && enc_err;

  // Illegal immediates are truncated into the word and only flagged, never dropped.
  always_comb begin
    enc_instr = {bus.i_rs2, bus.i_rs1, bus.i_rd, bus.i_opcode};
    enc_err   = 1'b0;
    case (bus.i_opcode)
      4'h9: begin
        enc_instr = {bus.i_imm[7:0], bus.i_rd, bus.i_opcode};
        enc_err   = (bus.i_imm[15:8] != {8{bus.i_imm[7]}}) || (bus.i_rs1 != bus.i_rd);
      end
      4'hA: begin
        enc_instr = {bus.i_imm[3:0], bus.i_rs1, bus.i_rd, bus.i_opcode};
        enc_err   = (bus.i_imm[15:4] != {12{bus.i_imm[3]}});
      end
      4'hB: begin
        enc_instr = {bus.i_rs2, bus.i_rs1, bus.i_imm[3:0], bus.i_opcode};
        enc_err   = (bus.i_imm[15:4] != {12{bus.i_imm[3]}});
      end
      default: begin
        enc_instr = {bus.i_rs2, bus.i_rs1, bus.i_rd, bus.i_opcode};
        enc_err   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Push without pop never happens in FULL because o_ready is low there.
  always_comb begin
    state_nxt      = state;
    load_head_new  = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_nxt     = ONE;
          load_head_new = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_head_new = 1'b1;
        end else if (push) begin
          state_nxt = FULL;
          load_tail = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_nxt      = ONE;
          load_head_tail = 1'b1;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_instr <= 16'h0000;
      head_err   <= 1'b0;
      tail_instr <= 16'h0000;
      tail_err   <= 1'b0;
    end else begin
      if (load_head_new) begin
        head_instr <= enc_instr;
        head_err   <= enc_err;
      end else if (load_head_tail) begin
        head_instr <= tail_instr;
        head_err   <= tail_err;
      end
      if (load_tail) begin
        tail_instr <= enc_instr;
        tail_err   <= enc_err;
      end
    end
  end

  // A clear coinciding with an illegal push leaves exactly that one error recorded.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      instr_cnt  <= '0;
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (push) begin
        instr_cnt <= instr_cnt + CNT_ONE;
      end
      if (bus.i_err_clr) begin
        err_cnt    <= err_push ? CNT_ONE : '0;
        err_sticky <= err_push;
      end else if (err_push) begin
        err_sticky <= 1'b1;
        if (err_cnt != CNT_MAX) begin
          err_cnt <= err_cnt + CNT_ONE;
        end
      end
    end
  end

  assign bus.o_instr      = head_instr;
  assign bus.o_err        = head_err;
  assign bus.o_err_sticky = err_sticky;
  assign bus.o_instr_cnt  = instr_cnt;
  assign bus.o_err_cnt    = err_cnt;

endmodule

// File: tb/tb_z16_encoder.sv
// Directed scoreboard bench for z16_encoder; uses a narrow counter width so
// wrap and saturation are reachable in a few cycles.
module tb_z16_encoder;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [16:0] sb[$];
  int          m_instr_cnt;
  int          m_err_cnt;
  int          m_sticky;
  bit          last_push;

  z16_encoder_if #(.CNT_W(CW)) bus ();

  z16_encoder #(.CNT_W(CW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected word from field ranges: imm must fit the signed field width.
  function automatic logic [16:0] model_encode(input logic [3:0] op, input logic [3:0] rd,
                                               input logic [3:0] rs1, input logic [3:0] rs2,
                                               input logic [15:0] imm);
    int          simm;
    logic [15:0] w;
    logic        e;
    simm = int'($signed(imm));
    w    = {rs2, rs1, rd, op};
    e    = 1'b0;
    if (op == 4'h9) begin
      w = {imm[7:0], rd, op};
      e = (simm < -128) || (simm > 127) || (rs1 != rd);
    end else if (op == 4'hA) begin
      w = {imm[3:0], rs1, rd, op};
      e = (simm < -8) || (simm > 7);
    end else if (op == 4'hB) begin
      w = {rs2, rs1, imm[3:0], op};
      e = (simm < -8) || (simm > 7);
    end
    return {e, w};
  endfunction

  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] rs1, input logic [3:0] rs2, input logic [15:0] imm);
    bus.i_valid  = v;
    bus.i_opcode = op;
    bus.i_rd     = rd;
    bus.i_rs1    = rs1;
    bus.i_rs2    = rs2;
    bus.i_imm    = imm;
  endtask

  task automatic model_reset();
    sb.delete();
    m_instr_cnt = 0;
    m_err_cnt   = 0;
    m_sticky    = 0;
  endtask

  // One clock: score pops/pushes seen before the edge, then check state after it.
  task automatic step();
    bit          push;
    bit          pop;
    logic [16:0] e;
    push = bus.i_valid && bus.o_ready;
    pop  = bus.o_valid && bus.i_ready;
    if (pop) begin
      if (sb.size() == 0) begin
        chk("pop_with_nothing_expected", 32'(bus.o_valid), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("head_instr", 32'(bus.o_instr), 32'(e[15:0]));
        chk("head_err", 32'(bus.o_err), 32'(e[16]));
      end
    end
    e = model_encode(bus.i_opcode, bus.i_rd, bus.i_rs1, bus.i_rs2, bus.i_imm);
    if (push) begin
      sb.push_back(e);
      m_instr_cnt = (m_instr_cnt + 1) % (CMAX + 1);
    end
    if (bus.i_err_clr) begin
      m_err_cnt = (push && e[16]) ? 1 : 0;
      m_sticky  = (push && e[16]) ? 1 : 0;
    end else if (push && e[16]) begin
      m_sticky = 1;
      if (m_err_cnt < CMAX) m_err_cnt++;
    end
    last_push = push;
    @(posedge clk);
    @(negedge clk);
    chk("o_valid", 32'(bus.o_valid), 32'(sb.size() > 0));
    chk("o_ready", 32'(bus.o_ready), 32'(sb.size() < 2));
    chk("instr_cnt", 32'(bus.o_instr_cnt), 32'(m_instr_cnt));
    chk("err_cnt", 32'(bus.o_err_cnt), 32'(m_err_cnt));
    chk("err_sticky", 32'(bus.o_err_sticky), 32'(m_sticky));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_push = 1'b0;
    model_reset();
    rst_n         = 1'b0;
    bus.i_ready   = 1'b0;
    bus.i_err_clr = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_o_valid", 32'(bus.o_valid), 32'(0));
    chk("rst_o_ready", 32'(bus.o_ready), 32'(1));
    chk("rst_o_instr", 32'(bus.o_instr), 32'(16'h0000));
    chk("rst_o_err", 32'(bus.o_err), 32'(0));
    chk("rst_sticky", 32'(bus.o_err_sticky), 32'(0));
    chk("rst_instr_cnt", 32'(bus.o_instr_cnt), 32'(0));
    chk("rst_err_cnt", 32'(bus.o_err_cnt), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // R-format, latency 1
    bus.i_ready = 1'b1;
    drive(1'b1, 4'h0, 4'h1, 4'h2, 4'h3, 16'hABCD);
    step();
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
    chk("r_instr", 32'(bus.o_instr), 32'(16'h3210));
    chk("r_err", 32'(bus.o_err), 32'(0));
    chk("r_cnt", 32'(bus.o_instr_cnt), 32'(1));
    step();

    // I-type legal then out-of-range immediate
    drive(1'b1, 4'h9, 4'h5, 4'h5, 4'h0, 16'hFFF0);
    step();
    chk("i_ok_instr", 32'(bus.o_instr), 32'(16'hF059));
    chk("i_ok_err", 32'(bus.o_err), 32'(0));
    drive(1'b1, 4'h9, 4'h5, 4'h5, 4'h0, 16'h0080);
    step();
    chk("i_bad_instr", 32'(bus.o_instr), 32'(16'h8059));
    chk("i_bad_err", 32'(bus.o_err), 32'(1));
    chk("i_bad_sticky", 32'(bus.o_err_sticky), 32'(1));
    chk("i_bad_errcnt", 32'(bus.o_err_cnt), 32'(1));
    drive(1'b1, 4'h9, 4'h5, 4'h6, 4'h0, 16'h0003);
    step();
    chk("i_rs1_ne_rd_err", 32'(bus.o_err), 32'(1));

    // Load / store
    drive(1'b1, 4'hA, 4'h4, 4'h2, 4'h0, 16'hFFFF);
    step();
    chk("ld_instr", 32'(bus.o_instr), 32'(16'hF24A));
    drive(1'b1, 4'hB, 4'h0, 4'h3, 4'h7, 16'h0005);
    step();
    chk("st_instr", 32'(bus.o_instr), 32'(16'h735B));
    chk("st_err", 32'(bus.o_err), 32'(0));
    drive(1'b1, 4'hB, 4'h0, 4'h3, 4'h7, 16'h0010);
    step();
    chk("st_bad_err", 32'(bus.o_err), 32'(1));
    chk("st_bad_instr", 32'(bus.o_instr), 32'(16'h730B));
    drive(1'b1, 4'hF, 4'hE, 4'hD, 4'hC, 16'h8000);
    step();
    chk("r_opF_instr", 32'(bus.o_instr), 32'(16'hCDEF));
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
    step();

    // Backpressure: two pushes fill, third held and its fields may wander
    bus.i_ready = 1'b0;
    m_instr_cnt = 0;
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 4'h1, 4'h1, 4'h1, 4'h1, 16'h0000);
    step();
    drive(1'b1, 4'h2, 4'h2, 4'h2, 4'h2, 16'h0000);
    step();
    chk("bp_ready_low", 32'(bus.o_ready), 32'(0));
    drive(1'b1, 4'h9, 4'h7, 4'h7, 4'h0, 16'h7FFF);
    step();
    drive(1'b1, 4'h3, 4'h3, 4'h3, 4'h3, 16'h0000);
    step();
    chk("bp_held_cnt", 32'(bus.o_instr_cnt), 32'(2));
    chk("bp_head_first", 32'(bus.o_instr), 32'(16'h1111));
    bus.i_ready = 1'b1;
    begin
      int n;
      n = 0;
      last_push = 1'b0;
      while (!last_push && n < 8) begin
        step();
        n++;
      end
      chk("bp_third_accepted", 32'(last_push), 32'(1));
    end
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
    chk("bp_cnt3", 32'(bus.o_instr_cnt), 32'(3));
    repeat (3) step();

    // Fill to FULL, then reset mid-operation
    bus.i_ready = 1'b0;
    drive(1'b1, 4'hA, 4'h1, 4'h1, 4'h0, 16'h0100);
    step();
    step();
    chk("full_ready", 32'(bus.o_ready), 32'(0));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.o_valid), 32'(0));
    chk("mid_rst_ready", 32'(bus.o_ready), 32'(1));
    chk("mid_rst_instr_cnt", 32'(bus.o_instr_cnt), 32'(0));
    chk("mid_rst_err_cnt", 32'(bus.o_err_cnt), 32'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
    @(negedge clk);

    // Saturate err_cnt and wrap instr_cnt
    bus.i_ready = 1'b1;
    drive(1'b1, 4'hA, 4'h1, 4'h2, 4'h0, 16'h0040);
    repeat (CMAX) step();
    chk("errcnt_at_max", 32'(bus.o_err_cnt), 32'(CMAX));
    step();
    chk("errcnt_saturated", 32'(bus.o_err_cnt), 32'(CMAX));
    chk("instr_cnt_wrapped", 32'(bus.o_instr_cnt), 32'(0));
    step();
    chk("instr_cnt_after_wrap", 32'(bus.o_instr_cnt), 32'(1));

    // Clear alone, then clear together with an illegal push
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
    bus.i_err_clr = 1'b1;
    step();
    chk("clr_errcnt", 32'(bus.o_err_cnt), 32'(0));
    chk("clr_sticky", 32'(bus.o_err_sticky), 32'(0));
    drive(1'b1, 4'hB, 4'h0, 4'h1, 4'h2, 16'hFF00);
    step();
    bus.i_err_clr = 1'b0;
    chk("clr_push_sticky", 32'(bus.o_err_sticky), 32'(1));
    chk("clr_push_errcnt", 32'(bus.o_err_cnt), 32'(1));

    // Drain
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
    begin
      int n;
      n = 0;
      while ((sb.size() > 0 || bus.o_valid) && n < 10) begin
        step();
        n++;
      end
      chk("drained", 32'(bus.o_valid), 32'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
